// File: rtl/bcd_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_timer_if
//  Description : Control and result bundle of the BCD elapsed-time counter.
//                The master side drives the run/load/capture controls and
//                observes the digits; the slave side is the timer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_timer_if #(
    parameter int DIGITS = 4
);
    logic                  clear;
    logic                  enable;
    logic                  up_dn;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  capture;
    logic [4*DIGITS-1:0]   count;
    logic [4*DIGITS-1:0]   lap;
    logic                  tick;
    logic                  at_limit;
    logic                  overflow;

    modport master (
        output clear,
        output enable,
        output up_dn,
        output load,
        output load_val,
        output capture,
        input  count,
        input  lap,
        input  tick,
        input  at_limit,
        input  overflow
    );

    modport slave (
        input  clear,
        input  enable,
        input  up_dn,
        input  load,
        input  load_val,
        input  capture,
        output count,
        output lap,
        output tick,
        output at_limit,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/bcd_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_timer
//  Description : N-digit BCD elapsed-time counter with built-in prescaler.
//                One count step every DIV enabled clock cycles; up/down,
//                wrap or saturate at the limits, preload, lap capture and a
//                sticky overflow flag. Digits feed the display mux directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_timer #(
    parameter int DIGITS   = 4,
    parameter int DIV      = 100000,
    parameter bit SATURATE = 1'b0
) (
    input  wire logic       ck,
    input  wire logic       reset,
    bcd_timer_if.slave      bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_w        = 4 * DIGITS;
    localparam int              c_pw       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_pw-1:0] c_pre_last = c_pw'(DIV - 1);
    localparam logic [c_pw-1:0] c_pre_one  = c_pw'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_pw-1:0] r_pre;
    logic [c_w-1:0]  r_count;
    logic [c_w-1:0]  r_lap;
    logic            r_ovf;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic            w_tick;
    logic [DIGITS:0] w_carry;      // w_carry[i]  : increment reaches digit i
    logic [DIGITS:0] w_borrow;     // w_borrow[i] : decrement reaches digit i
    logic [c_w-1:0]  w_inc;
    logic [c_w-1:0]  w_dec;
    logic [c_w-1:0]  w_load_clamped;
    logic            w_all9;
    logic            w_all0;
    logic            w_at_limit;
    logic [c_w-1:0]  w_step_val;

    // The prescaler wraps on the tick cycle, so its terminal value is the tick.
    assign w_tick = bus.enable && (r_pre == c_pre_last);

    // A step always starts by adding/subtracting one at the least significant
    // digit; the carry/borrow then ripples upward within the same cycle.
    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] w_d;
            logic [3:0] w_ld;

            assign w_d = r_count[4*i +: 4];

            // Increment: a 9 receiving a carry rolls to 0 and passes it on.
            assign w_carry[i+1]   = w_carry[i] && (w_d == 4'd9);
            assign w_inc[4*i +: 4] = !w_carry[i]   ? w_d :
                                     (w_d == 4'd9) ? 4'd0 : (w_d + 4'd1);

            // Decrement: a 0 receiving a borrow rolls to 9 and passes it on.
            assign w_borrow[i+1]   = w_borrow[i] && (w_d == 4'd0);
            assign w_dec[4*i +: 4] = !w_borrow[i]  ? w_d :
                                     (w_d == 4'd0) ? 4'd9 : (w_d - 4'd1);

            // Preload digits above 9 are forced to 9 so the count stays BCD.
            assign w_ld                     = bus.load_val[4*i +: 4];
            assign w_load_clamped[4*i +: 4] = (w_ld > 4'd9) ? 4'd9 : w_ld;
        end
    endgenerate

    // A carry out of the top digit means every digit was 9; likewise for 0.
    assign w_all9     = w_carry[DIGITS];
    assign w_all0     = w_borrow[DIGITS];
    assign w_at_limit = bus.up_dn ? w_all9 : w_all0;

    // The ripple result already wraps (9999+1 -> 0000, 0000-1 -> 9999);
    // saturation simply keeps the current value at the limit.
    assign w_step_val = (SATURATE && w_at_limit) ? r_count :
                        (bus.up_dn ? w_inc : w_dec);

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Prescaler, count and overflow: reset > clear > load > step.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (bus.clear) begin
            r_pre   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (bus.load) begin
            r_pre   <= '0;
            r_count <= w_load_clamped;
        end else begin
            if (bus.enable) begin
                r_pre <= w_tick ? '0 : (r_pre + c_pre_one);
            end
            if (w_tick) begin
                r_count <= w_step_val;
                if (w_at_limit) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    // Lap register: samples the count visible this cycle, before any update.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_lap <= '0;
        end else if (bus.capture) begin
            r_lap <= r_count;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.count    = r_count;
    assign bus.lap      = r_lap;
    assign bus.tick     = w_tick;
    assign bus.at_limit = w_at_limit;
    assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/bcd_timer.md
Name: bcd_timer

Overview:
- Parametrised N-digit BCD elapsed-time counter with a built-in prescaler. Produces one count step every DIV clock cycles while enabled.
- Supports up/down counting, wrap or saturate at the limits, parallel preload, lap capture and a sticky overflow flag.
- Drives the reflex-measurement display and scoring logic directly: the digits go to the 7-segment mux, the lap value to result storage.

Parameters:
DIGITS, 4, number of BCD digits; count range 0 .. 10^DIGITS-1
DIV, 100000, clock cycles per count step (1 ms at 100 MHz); legal range 1 .. 2^24
SATURATE, 0, 0 = wrap at limits, 1 = hold at limit

Ports:
ck  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high; forces all state to reset values
clear  in  1  synchronous clear of count, prescaler and overflow
enable  in  1  run; prescaler and count advance only while high
up_dn  in  1  1 = count up, 0 = count down
load  in  1  synchronous preload of count from load_val
load_val  in  4*DIGITS  preload value, digit 0 in bits [3:0]
capture  in  1  copy current count into lap
count  out  4*DIGITS  current BCD value, digit 0 = least significant (ms)
lap  out  4*DIGITS  last captured value
tick  out  1  combinational; high in the cycle a count step is applied
at_limit  out  1  combinational; count == all-9s when up_dn=1, count == 0 when up_dn=0
overflow  out  1  sticky; a step attempted past a limit

Behaviour:
- Reset value: count = 0, lap = 0, prescaler = 0, overflow = 0. Combinational outputs follow from this: tick = 0 unless enable && DIV==1; at_limit = ~up_dn.
- Prescaler runs 0 .. DIV-1.
  - Increments only when enable=1 and holds when enable=0; no drift across pause/resume.
  - tick = enable && (prescaler == DIV-1). On a tick edge the prescaler returns to 0.
  - DIV=1 gives a tick every enabled cycle.
- Count step, applied on the rising edge where tick=1:
  - Up: digit 0 increments. Each digit at 9 with an incoming carry goes to 0 and carries into the next digit (ripple within the same cycle).
  - Down: mirror behaviour; a digit at 0 with an incoming borrow goes to 9 and borrows from the next digit.
  - Latency: count changes on the edge following the cycle tick is high. The first step after clear/reset occurs DIV enabled cycles later.
- Limits:
  - Up step from all-9s: SATURATE=0 wraps to 0; SATURATE=1 holds all-9s. Both set overflow.
  - Down step from 0: SATURATE=0 wraps to all-9s; SATURATE=1 holds 0. Both set overflow.
  - overflow stays set until clear or reset.
- Priority, same edge: reset > clear > load > step.
  - clear: count = 0, prescaler = 0, overflow = 0. A tick in the same cycle is discarded.
  - load: count = load_val with each digit >9 clamped to 9; prescaler = 0; overflow unchanged. A coincident step is discarded.
  - up_dn may change any cycle and takes effect at the next step.
- capture:
  - Samples the count register value before the same-edge update, i.e. the value visible in that cycle.
  - Independent of clear/load/enable; capture together with clear stores the pre-clear value.
  - lap holds its value otherwise and is cleared only by reset.
- Reset mid-count: all registers go to reset values immediately and asynchronously. Operation restarts on the first edge after reset deasserts.
- All digits are always valid BCD (0-9). No unreachable states.
- Widths: prescaler is clog2(DIV) bits, minimum 1. Digit arithmetic is 4-bit, with no binary-to-BCD conversion.

Test Plan:
- DIGITS=4, DIV=4, SATURATE=0, up: reset, then enable for 40 cycles -> tick every 4th cycle, count = 0010. Pause enable 7 cycles then resume: next tick exactly 4 enabled cycles after the last one.
- Load 0998, up, DIV=1, 3 enabled cycles -> 0999, 1000, 1001. Load 9999 plus one step -> 0000, overflow=1. Then clear -> count 0000, overflow=0.
- SATURATE=1 instance: load 9999 up, 5 steps -> stays 9999, at_limit=1, overflow=1. up_dn=0 from 0000 -> stays 0000, overflow=1.
- Down, DIV=1: load 1000 -> 0999, 0998. With SATURATE=0, load 0000 plus one step -> 9999, overflow=1.
- Coincident events: in a tick cycle at count 0041, assert capture+clear -> lap=0041, count=0000. load 0500 with tick -> count=0500. load_val digit 0xC -> loaded as 9.
- Assert reset mid-count at 0123 between clock edges -> count, lap and overflow go to 0 without a clock edge. After release, first step comes DIV enabled cycles later.
